// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - execute-side request/response and memory bus bundle for the load/store unit
interface load_store_unit_if #(
  parameter int XLEN = 32
) ();
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [1:0]      req_width;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_fault;
  logic [XLEN-1:0] resp_rdata;
  logic [XLEN-1:0] mem_addr;
  logic [1:0]      mem_wwidth;
  logic            mem_wenable;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  // master: execute stage plus memory; slave: the load/store unit itself
  modport master (
    output req_valid, req_write, req_width, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_fault, resp_rdata,
    input  mem_addr, mem_wwidth, mem_wenable, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_width, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_fault, resp_rdata,
    output mem_addr, mem_wwidth, mem_wenable, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store initiator with alignment/ROM-store fault detection
module load_store_unit #(
  parameter int              XLEN         = 32,
  parameter int              READ_LATENCY = 1,
  parameter logic [XLEN-1:0] ROM_END      = 32'h0800
) (
  input logic              clock,
  input logic              reset,
  load_store_unit_if.slave bus
);

  localparam logic [1:0] WRITE_BYTE     = 2'd0;
  localparam logic [1:0] WRITE_HALFWORD = 2'd1;
  localparam logic [1:0] WRITE_WORD     = 2'd2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic            write_q;
  logic            unsigned_q;
  logic [1:0]      width_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] data_q;
  logic            fault_q;
  logic [7:0]      wait_cnt;

  logic            req_fault;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] load_value;

  always_comb begin
    req_fault = 1'b0;
    if (bus.req_width == WRITE_HALFWORD && bus.req_addr[0])
      req_fault = 1'b1;
    if (bus.req_width == WRITE_WORD && bus.req_addr[1:0] != 2'b00)
      req_fault = 1'b1;
    if (bus.req_write && bus.req_addr < ROM_END)
      req_fault = 1'b1;
  end

  // ROM returns the whole aligned word, so the addressed lane must be shifted down;
  // every other region already presents the addressed byte in [7:0].
  always_comb begin
    lane       = (addr_q < ROM_END) ? (bus.mem_rdata >> {addr_q[1:0], 3'b000}) : bus.mem_rdata;
    load_value = lane;
    case (width_q)
      WRITE_BYTE:
        load_value = unsigned_q ? {{(XLEN-8){1'b0}}, lane[7:0]} : {{(XLEN-8){lane[7]}}, lane[7:0]};
      WRITE_HALFWORD:
        load_value = unsigned_q ? {{(XLEN-16){1'b0}}, lane[15:0]} : {{(XLEN-16){lane[15]}}, lane[15:0]};
      default:
        load_value = lane;
    endcase
  end

  assign bus.req_ready = (state == IDLE) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      write_q         <= 1'b0;
      unsigned_q      <= 1'b0;
      width_q         <= WRITE_WORD;
      addr_q          <= '0;
      data_q          <= '0;
      fault_q         <= 1'b0;
      wait_cnt        <= 8'd0;
      bus.resp_valid  <= 1'b0;
      bus.resp_fault  <= 1'b0;
      bus.resp_rdata  <= '0;
      bus.mem_addr    <= '0;
      bus.mem_wwidth  <= WRITE_WORD;
      bus.mem_wenable <= 1'b0;
      bus.mem_wdata   <= '0;
    end else begin
      bus.resp_valid  <= 1'b0;
      bus.mem_wenable <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            write_q    <= bus.req_write;
            unsigned_q <= bus.req_unsigned;
            width_q    <= bus.req_width;
            addr_q     <= bus.req_addr;
            data_q     <= '0;
            fault_q    <= req_fault;
            if (req_fault) begin
              state <= RESP;
            end else begin
              bus.mem_addr    <= bus.req_addr;
              bus.mem_wwidth  <= bus.req_width;
              bus.mem_wdata   <= bus.req_wdata;
              bus.mem_wenable <= bus.req_write;
              state           <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (write_q) begin
            state <= RESP;
          end else if (READ_LATENCY == 0) begin
            data_q <= load_value;
            state  <= RESP;
          end else begin
            wait_cnt <= 8'd1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 8'(READ_LATENCY)) begin
            data_q <= load_value;
            state  <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          bus.resp_valid <= 1'b1;
          bus.resp_fault <= fault_q;
          bus.resp_rdata <= data_q;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a small ROM/RAM model
module tb_load_store_unit;

  localparam logic [1:0] W_B = 2'd0;
  localparam logic [1:0] W_H = 2'd1;
  localparam logic [1:0] W_W = 2'd2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  load_store_unit_if #(.XLEN(32)) bus ();

  load_store_unit #(.XLEN(32), .READ_LATENCY(1), .ROM_END(32'h0800)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {logic fault; logic [31:0] rdata; int lat; int acc;} resp_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; logic [1:0] width;} wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    last_acc = 0;

  logic [7:0] ram [0:255];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (a < 32'h0800)
      return (a[31:2] == 30'd0) ? 32'h80FF1234 : 32'h0;
    else if (a[31:8] == 24'h8)
      return {ram[a[7:0] + 8'd3], ram[a[7:0] + 8'd2], ram[a[7:0] + 8'd1], ram[a[7:0]]};
    else
      return 32'h0;
  endfunction

  // Memory: one-edge read latency; RAM at 0x0800 reloaded with known contents on reset
  always @(posedge clock) begin
    cyc++;
    if (bus.mem_wenable && bus.mem_addr[31:8] == 24'h8) begin
      for (int k = 0; k < 4; k++)
        if (k < ((bus.mem_wwidth == W_B) ? 1 : (bus.mem_wwidth == W_H) ? 2 : 4))
          ram[bus.mem_addr[7:0] + 8'(k)] <= bus.mem_wdata[8*k +: 8];
    end else if (reset) begin
      for (int k = 0; k < 256; k++) ram[k] <= 8'h00;
      ram[4] <= 8'hBB;
      ram[5] <= 8'hAA;
      ram[6] <= 8'h99;
      ram[7] <= 8'h88;
    end
    bus.mem_rdata <= mem_read(bus.mem_addr);
  end

  always @(negedge clock) begin
    resp_t r;
    wr_t   w;
    if (!reset && bus.resp_valid) begin
      if (resp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=resp_valid required=none");
      end else begin
        r = resp_q.pop_front();
        check("resp_fault", 32'(bus.resp_fault), 32'(r.fault));
        check("resp_rdata", bus.resp_rdata, r.rdata);
        check("resp_latency", 32'(cyc - r.acc - 1), 32'(r.lat));
      end
    end
    if (bus.mem_wenable) begin
      if (wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=addr %h required=none", bus.mem_addr);
      end else begin
        w = wr_q.pop_front();
        check("mem_addr", bus.mem_addr, w.addr);
        check("mem_wdata", bus.mem_wdata, w.data);
        check("mem_wwidth", 32'(bus.mem_wwidth), 32'(w.width));
      end
    end
  end

  task automatic issue(input logic wr, input logic [1:0] w, input logic uns, input logic [31:0] a,
                       input logic [31:0] d, input logic ef, input logic [31:0] ed, input int lat,
                       input bit expect_resp, input bit hold);
    resp_t r;
    wr_t   x;
    int    n;
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_width    = w;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = d;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=req_ready 0 required=1 addr=%h", a);
      bus.req_valid = 1'b0;
      return;
    end
    last_acc = cyc;
    if (expect_resp) begin
      r.fault = ef; r.rdata = ed; r.lat = lat; r.acc = cyc;
      resp_q.push_back(r);
    end
    if (wr && !ef) begin
      x.addr = a; x.data = d; x.width = w;
      wr_q.push_back(x);
    end
    @(negedge clock);
    check("ready_low_after_accept", 32'(bus.req_ready), 32'd0);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (resp_q.size() != 0 || wr_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending required=0", resp_q.size() + wr_q.size());
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a1, a2, a3;
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_width    = W_W;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    repeat (3) @(negedge clock);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    check("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset_resp_rdata", bus.resp_rdata, 32'h0);
    check("reset_mem_wenable", 32'(bus.mem_wenable), 32'd0);
    check("reset_mem_addr", bus.mem_addr, 32'h0);
    check("reset_mem_wwidth", 32'(bus.mem_wwidth), 32'(W_W));
    reset = 1'b0;
    #1;
    check("ready_after_reset", 32'(bus.req_ready), 32'd1);
    @(negedge clock);

    // loads: RAM word and sign/zero-extended ROM and RAM lanes
    issue(0, W_W, 0, 32'h0804, 0, 0, 32'h8899AABB, 3, 1, 0);
    issue(0, W_B, 0, 32'h0003, 0, 0, 32'hFFFFFF80, 3, 1, 0);
    issue(0, W_B, 1, 32'h0003, 0, 0, 32'h00000080, 3, 1, 0);
    issue(0, W_B, 0, 32'h0001, 0, 0, 32'h00000012, 3, 1, 0);
    issue(0, W_H, 0, 32'h0002, 0, 0, 32'hFFFF80FF, 3, 1, 0);
    issue(0, W_H, 1, 32'h0002, 0, 0, 32'h000080FF, 3, 1, 0);
    issue(0, W_H, 1, 32'h0000, 0, 0, 32'h00001234, 3, 1, 0);
    issue(0, W_H, 0, 32'h0806, 0, 0, 32'hFFFF8899, 3, 1, 0);
    issue(0, W_B, 0, 32'h0805, 0, 0, 32'hFFFFFFAA, 3, 1, 0);
    issue(0, W_B, 1, 32'h0805, 0, 0, 32'h000000AA, 3, 1, 0);
    drain();

    // stores, including first RAM byte right at the ROM boundary
    issue(1, W_H, 0, 32'h1800, 32'h0000BEEF, 0, 32'h0, 2, 1, 0);
    issue(1, W_W, 0, 32'h0808, 32'h11223344, 0, 32'h0, 2, 1, 0);
    issue(0, W_W, 0, 32'h0808, 0, 0, 32'h11223344, 3, 1, 0);
    issue(1, W_B, 0, 32'h0800, 32'hABCDEF7F, 0, 32'h0, 2, 1, 0);
    issue(0, W_B, 0, 32'h0800, 0, 0, 32'h0000007F, 3, 1, 0);
    drain();

    // faults: misaligned and ROM stores never reach memory
    issue(0, W_W, 0, 32'h0802, 0, 1, 32'h0, 1, 1, 0);
    issue(1, W_W, 0, 32'h0010, 32'hDEADBEEF, 1, 32'h0, 1, 1, 0);
    issue(1, W_B, 0, 32'h07FF, 32'h000000FF, 1, 32'h0, 1, 1, 0);
    issue(0, W_H, 0, 32'h0805, 0, 1, 32'h0, 1, 1, 0);
    issue(1, W_H, 0, 32'h0801, 32'h00001111, 1, 32'h0, 1, 1, 0);
    drain();
    check("resp_fault_held", 32'(bus.resp_fault), 32'd1);
    check("resp_valid_pulse", 32'(bus.resp_valid), 32'd0);

    // back-to-back with req_valid held
    issue(0, W_W, 0, 32'h0804, 0, 0, 32'h8899AABB, 3, 1, 1);
    a1 = last_acc;
    issue(0, W_B, 1, 32'h0807, 0, 0, 32'h00000088, 3, 1, 1);
    a2 = last_acc;
    issue(0, W_H, 1, 32'h0804, 0, 0, 32'h0000AABB, 3, 1, 0);
    a3 = last_acc;
    check("b2b_spacing_1", 32'(a2 - a1), 32'd4);
    check("b2b_spacing_2", 32'(a3 - a2), 32'd4);
    drain();

    // reset during the WAIT state of a load abandons it
    issue(0, W_W, 0, 32'h0804, 0, 0, 32'h0, 3, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midreset_req_ready", 32'(bus.req_ready), 32'd0);
    check("midreset_resp_valid", 32'(bus.resp_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("ready_after_midreset", 32'(bus.req_ready), 32'd1);
    repeat (3) @(negedge clock);
    issue(0, W_W, 0, 32'h0804, 0, 0, 32'h8899AABB, 3, 1, 0);
    drain();

    check("resp_queue_empty", 32'(resp_q.size()), 32'd0);
    check("write_queue_empty", 32'(wr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
